// File: rtl/main_control_fsm.sv
// Multi-cycle RISC-V main control FSM: fetch, decode, execute, memory and write-back sequencing.
// Optional macro MAIN_CTRL_HALT_EN: SYSTEM opcodes park the FSM in HALT instead of retiring like FENCE.
module main_control_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic [1:0] ALUOP,
    output logic       alu_src_b,
    output logic       ir_we,
    output logic       pc_we,
    output logic       rf_we,
    output logic [1:0] pc_src,
    output logic [1:0] wb_sel,
    output logic       illegal,
    output logic [2:0] state
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        CL_R, CL_IALU, CL_UPPER, CL_LOAD, CL_STORE,
        CL_BRANCH, CL_JUMP, CL_FENCE, CL_SYSTEM, CL_ILLEGAL
    } class_t;

    state_t r_state;
    state_t w_next_state;
    class_t r_class;
    class_t w_class;

    // Opcode to instruction class; only sampled while in DECODE
    always_comb begin
        w_class = CL_ILLEGAL;
        case (opcode)
            OP_R:              w_class = CL_R;
            OP_IALU:           w_class = CL_IALU;
            OP_LUI, OP_AUIPC:  w_class = CL_UPPER;
            OP_LOAD:           w_class = CL_LOAD;
            OP_STORE:          w_class = CL_STORE;
            OP_BRANCH:         w_class = CL_BRANCH;
            OP_JAL, OP_JALR:   w_class = CL_JUMP;
            OP_FENCE:          w_class = CL_FENCE;
`ifdef MAIN_CTRL_HALT_EN
            OP_SYSTEM:         w_class = CL_SYSTEM;
`else
            OP_SYSTEM:         w_class = CL_FENCE;
`endif
            default:           w_class = CL_ILLEGAL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_class <= CL_ILLEGAL;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_DECODE) begin
                r_class <= w_class;
            end
        end
    end

    // Next state and control outputs; outputs are decoded from the state flop so reset clears them at once
    always_comb begin
        w_next_state = r_state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        ALUOP        = 2'b00;
        alu_src_b    = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        rf_we        = 1'b0;
        pc_src       = 2'b00;
        wb_sel       = 2'b00;
        illegal      = 1'b0;
        case (r_state)
            S_IDLE: w_next_state = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we        = 1'b1;
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_class == CL_ILLEGAL) begin
                    w_next_state = S_TRAP;
`ifdef MAIN_CTRL_HALT_EN
                end else if (w_class == CL_SYSTEM) begin
                    w_next_state = S_HALT;
`endif
                end else begin
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                case (r_class)
                    CL_R: begin
                        ALUOP        = 2'b10;
                        w_next_state = S_WB;
                    end
                    CL_IALU: begin
                        ALUOP        = 2'b10;
                        alu_src_b    = 1'b1;
                        w_next_state = S_WB;
                    end
                    CL_UPPER, CL_JUMP: begin
                        alu_src_b    = 1'b1;
                        w_next_state = S_WB;
                    end
                    CL_LOAD, CL_STORE: begin
                        alu_src_b    = 1'b1;
                        w_next_state = S_MEM;
                    end
                    CL_BRANCH: begin
                        ALUOP        = 2'b01;
                        pc_we        = 1'b1;
                        pc_src       = branch_taken ? 2'b01 : 2'b00;
                        w_next_state = S_FETCH;
                    end
                    default: begin
                        pc_we        = 1'b1;
                        w_next_state = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (r_class == CL_STORE);
                if (mem_ready) begin
                    if (r_class == CL_STORE) begin
                        pc_we        = 1'b1;
                        w_next_state = S_FETCH;
                    end else begin
                        w_next_state = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we        = 1'b1;
                pc_we        = 1'b1;
                w_next_state = S_FETCH;
                if (r_class == CL_LOAD) begin
                    wb_sel = 2'b01;
                end else if (r_class == CL_JUMP) begin
                    wb_sel = 2'b10;
                    pc_src = 2'b10;
                end
            end
            S_TRAP: illegal = 1'b1;
            S_HALT: w_next_state = S_HALT;
            default: w_next_state = S_IDLE;
        endcase
    end

    assign state = r_state;

endmodule
